i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
- Parametrised I2C target (slave) with a register file, generalised in register count and target address.
- Runs on the system clock; SCL/SDA are oversampled through 2-flop synchronisers with edge detection.
- Adds behaviour the prior generation lacks: repeated START, pointer auto-increment with wrap, NACK of out-of-range pointers, a read-only status register, and per-write strobes.
- Sits between the chip pads (open-drain SDA) and on-chip logic consuming the registers.

Parameters:
- REG_COUNT, 16, number of 8-bit registers (2..32); index 0 is read-only status.
- BASE_ADDR, 7'h20, 7-bit target address before addr_sel offset.
- SEL_W, 2, width of addr_sel; effective address = BASE_ADDR | addr_sel.
- TIMEOUT_CYCLES, 1_000_000, SCL-low limit in clocks (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- scl_in  in  1  raw SCL pad input (async).
- sda_in  in  1  raw SDA pad input (async).
- addr_sel  in  SEL_W  address offset strap; sampled continuously.
- parallel_in  in  8  status value returned on reads of register 0.
- sda_oe  out  1  1 = drive SDA low, 0 = release.
- reg_out  out  8  contents of the register at the current pointer.
- registers_packed  out  8*REG_COUNT  all registers; reg i at [8i+7:8i]; reg 0 slice = parallel_in.
- wr_strobe  out  1  one-cycle pulse when a register write commits.
- wr_index  out  $clog2(REG_COUNT)  index of the committed write; valid with wr_strobe.

Behaviour:
- Reset: state IDLE, pointer 0, all registers 0, sda_oe 0, wr_strobe 0, wr_index 0, bit counter 0.
- Synchronisation and edges: 2-flop synchronisers; edges are detected from the synced value. A bus event becomes visible to the FSM 3 clocks after the pad change.
- START: SDA negedge while synced SCL is high. From any state, clears the bit counter and enters ADDR. This covers repeated START.
- STOP: SDA posedge while SCL is high. From any state, returns to IDLE and releases sda_oe.
- Bit sampling: SDA is sampled on SCL posedge, MSB first; the bit counter goes 0..7 and wraps after the ACK bit.
- sda_oe changes only on SCL negedge, never while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_CHK.
- ADDR: after 8 bits, compare bits[7:1] to BASE_ADDR | addr_sel.
  - Mismatch: IDLE, no ACK.
  - Match with R/W=0: ADDR_ACK, then PTR.
  - Match with R/W=1: ADDR_ACK, then RDATA; the MSB of the register at the pointer is driven on the ACK negedge.
- PTR: the byte is the new pointer.
  - Value ≥ REG_COUNT: NACK, pointer unchanged, go to IDLE.
  - Otherwise: ACK, go to WDATA.
- WDATA: after 8 bits, ACK.
  - If pointer ≠ 0: write the register, pulse wr_strobe for one clock at the 8th SCL posedge, and set wr_index = pointer.
  - Pointer 0 is ACKed but not written and produces no strobe.
  - Then increment the pointer, wrapping REG_COUNT-1 → 0.
- RDATA: shift out the register at the pointer (register 0 reads parallel_in). The data byte is latched at byte start, so mid-byte host changes do not tear it. Increment the pointer after the 8th bit; release SDA for the ACK bit.
- RACK_CHK: controller ACK (0) returns to RDATA with the next byte; NACK (1) goes to IDLE.
- reg_out always reflects the register at the current pointer, combinationally from state.
- Reset asserted mid-transfer releases SDA in the same cycle and abandons the transaction.

Optional Feature:
- Macro: I2C_TIMEOUT_EN.
- Defined:
  - A counter runs while synced SCL is low and the state is not IDLE.
  - Reaching TIMEOUT_CYCLES forces IDLE, sda_oe 0, and counter cleared.
  - Registers are unaffected.
- Undefined: no counter is instantiated; the FSM leaves a stalled bus only on STOP, START or reset.

Decomposition:
- Package i2c_pkg:
  - state enum i2c_state_t;
  - ACK = 1'b0, NACK = 1'b1;
  - function clog2-safe index width.
- Natural sub-module: i2c_sync_edge (2-flop synchroniser plus posedge/negedge pulses), instantiated for SCL and SDA.

Test Plan:
- addr_sel=2'b01; write 0x21<<1, pointer 0x03, data 0xA5, STOP -> ACK on all three bytes; reg 3 = 0xA5; wr_strobe one pulse with wr_index=3.
- Burst write at pointer 0x0F (REG_COUNT=16) of 0x11 then 0x22 -> reg15=0x11; pointer wraps; reg0 unchanged with no strobe; reg1 unchanged.
- Set pointer 0x02, repeated START, read 2 bytes (ACK then NACK), parallel_in=0x5C -> returns reg2, then reg3; a separate read at pointer 0 returns 0x5C.
- Address 0x30 -> SDA never driven; registers and pointer unchanged.
- Pointer 0x20 -> NACK on the pointer byte, FSM returns to IDLE, following data bytes ignored.
- With I2C_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold SCL low mid-read while driving 0 -> sda_oe released after 100 clocks and state is IDLE; reset asserted mid-byte -> sda_oe 0 on the next clock.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C target register file.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK_CHK
    } i2c_state_t;

    // Acknowledge bit polarity on SDA.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 2) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad input, with edge pulses
// derived from the synchronised level.
module i2c_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    // Shift the pad through two sync stages plus one history stage; resets high (idle bus).
    always_ff @(posedge clock) begin
        if (reset) sr <= '1;
        else       sr <= {sr[1:0], pin};
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a pointer-addressed register file. Register 0 is a
// read-only status byte taken from parallel_in.
// Optional SCL-low watchdog: define I2C_TIMEOUT_EN.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter int unsigned REG_COUNT      = 16,
    parameter logic [6:0]  BASE_ADDR      = 7'h20,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             scl_in,
    input  logic                             sda_in,
    input  logic [SEL_W-1:0]                 addr_sel,
    input  logic [7:0]                       parallel_in,
    output logic                             sda_oe,
    output logic [7:0]                       reg_out,
    output logic [8*REG_COUNT-1:0]           registers_packed,
    output logic                             wr_strobe,
    output logic [idx_width(REG_COUNT)-1:0]  wr_index
);

    localparam int unsigned IDX_W = idx_width(REG_COUNT);

    i2c_state_t       state, state_next;
    logic [7:0]       regs [REG_COUNT];
    logic [IDX_W-1:0] ptr, ptr_inc;
    logic [7:0]       shift, shift_next, tx_byte;
    logic [2:0]       bit_cnt;
    logic             rw;
    logic             scl_lvl, scl_rise, scl_fall;
    logic             sda_lvl, sda_rise, sda_fall;
    logic             start, stop, last_bit, addr_match, ptr_ok, timeout;

    i2c_sync_edge u_scl_sync (
        .clock (clock),
        .reset (reset),
        .pin   (scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clock (clock),
        .reset (reset),
        .pin   (sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    assign start      = sda_fall & scl_lvl;
    assign stop       = sda_rise & scl_lvl;
    assign shift_next = {shift[6:0], sda_lvl};
    assign last_bit   = (bit_cnt == 3'd7);
    assign addr_match = (shift[6:0] == (BASE_ADDR | 7'(addr_sel)));
    assign ptr_ok     = (32'(shift_next) < REG_COUNT);
    assign ptr_inc    = (32'(ptr) == REG_COUNT - 1) ? '0 : ptr + 1'b1;
    assign reg_out    = (ptr == '0) ? parallel_in : regs[ptr];

`ifdef I2C_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout = (state != IDLE) && !scl_lvl && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Count clocks of SCL held low during a transaction; cleared on any SCL high or abort.
    always_ff @(posedge clock) begin
        if (reset || timeout || scl_lvl || state == IDLE) to_cnt <= '0;
        else                                              to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: bus conditions override byte progress.
    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = ADDR;
        end else if (stop) begin
            state_next = IDLE;
        end else if (scl_rise) begin
            case (state)
                ADDR:      if (last_bit) state_next = addr_match ? ADDR_ACK : IDLE;
                ADDR_ACK:  state_next = rw ? RDATA : PTR;
                PTR:       if (last_bit) state_next = ptr_ok ? PTR_ACK : IDLE;
                PTR_ACK:   state_next = WDATA;
                WDATA:     if (last_bit) state_next = WDATA_ACK;
                WDATA_ACK: state_next = WDATA;
                RDATA:     if (last_bit) state_next = RACK_CHK;
                RACK_CHK:  state_next = (sda_lvl == NACK) ? IDLE : RDATA;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Datapath: sample on SCL rise, change SDA drive only on SCL fall.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs      <= '{default: '0};
            ptr       <= '0;
            shift     <= '0;
            tx_byte   <= '0;
            bit_cnt   <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (timeout) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else if (start) begin
                bit_cnt <= '0;
            end else if (stop) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
            end else if (scl_rise) begin
                case (state)
                    ADDR, PTR, WDATA, RDATA: begin
                        shift   <= shift_next;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    default: ;
                endcase
                case (state)
                    ADDR:     if (last_bit) rw <= sda_lvl;
                    ADDR_ACK: if (rw) tx_byte <= reg_out;
                    PTR:      if (last_bit && ptr_ok) ptr <= shift_next[IDX_W-1:0];
                    WDATA: begin
                        if (last_bit) begin
                            if (ptr != '0) begin
                                regs[ptr] <= shift_next;
                                wr_strobe <= 1'b1;
                                wr_index  <= ptr;
                            end
                            ptr <= ptr_inc;
                        end
                    end
                    RDATA:    if (last_bit) ptr <= ptr_inc;
                    RACK_CHK: if (sda_lvl == ACK) tx_byte <= reg_out;
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe <= ~ACK;
                    RDATA:                        sda_oe <= ~tx_byte[3'd7 - bit_cnt];
                    default:                      sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Flatten the register file; slot 0 mirrors the live status input.
    always_comb begin
        registers_packed      = '0;
        registers_packed[7:0] = parallel_in;
        for (int unsigned i = 1; i < REG_COUNT; i++) begin
            registers_packed[8*i +: 8] = regs[i];
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile (REG_COUNT=16, address 0x21).
module tb_i2c_target_regfile;

    localparam int unsigned Q = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         scl_host, sda_host;
    logic         sda_bus;
    logic [1:0]   addr_sel;
    logic [7:0]   parallel_in;
    logic         sda_oe;
    logic [7:0]   reg_out;
    logic [127:0] registers_packed;
    logic         wr_strobe;
    logic [3:0]   wr_index;

    int           checks = 0;
    int           errors = 0;
    int           strobe_cnt;
    logic [3:0]   last_idx;
    logic         oe_seen;
    logic [7:0]   exp_regs [16];
    logic         a;
    logic [7:0]   d;

    assign sda_bus = sda_host & ~sda_oe;

    always #5 clock = ~clock;

    i2c_target_regfile #(
        .REG_COUNT      (16),
        .BASE_ADDR      (7'h20),
        .SEL_W          (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .scl_in           (scl_host),
        .sda_in           (sda_bus),
        .addr_sel         (addr_sel),
        .parallel_in      (parallel_in),
        .sda_oe           (sda_oe),
        .reg_out          (reg_out),
        .registers_packed (registers_packed),
        .wr_strobe        (wr_strobe),
        .wr_index         (wr_index)
    );

    always @(posedge clock) begin
        if (wr_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_idx   = wr_index;
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_packed();
        logic [127:0] p;
        p[7:0] = parallel_in;
        for (int unsigned i = 1; i < 16; i++) p[8*i +: 8] = exp_regs[i];
        return p;
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        sda_host = b;   tick(Q);
        scl_host = 1'b1; tick(2*Q);
        scl_host = 1'b0; tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_host = 1'b1; tick(Q);
        scl_host = 1'b1; tick(Q);
        b = sda_bus;     tick(Q);
        scl_host = 1'b0; tick(Q);
    endtask

    task automatic start_cond();
        sda_host = 1'b1; tick(Q);
        scl_host = 1'b1; tick(Q);
        sda_host = 1'b0; tick(Q);
        scl_host = 1'b0; tick(Q);
    endtask

    task automatic stop_cond();
        sda_host = 1'b0; tick(Q);
        scl_host = 1'b1; tick(Q);
        sda_host = 1'b1; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        for (int unsigned i = 0; i < 8; i++) send_bit(data[7-i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] data);
        logic b;
        for (int unsigned i = 0; i < 8; i++) begin
            recv_bit(b);
            data[7-i] = b;
        end
        send_bit(ack_bit);
    endtask

    task automatic wr_reg(input logic [7:0] ptr, input logic [7:0] data);
        logic ack;
        start_cond();
        write_byte(8'h42, ack); check("wr_addr_ack", ack, 1'b0);
        write_byte(ptr, ack);   check("wr_ptr_ack", ack, 1'b0);
        write_byte(data, ack);  check("wr_data_ack", ack, 1'b0);
        stop_cond();
        exp_regs[ptr[3:0]] = data;
    endtask

    initial begin
        reset = 1'b1; scl_host = 1'b1; sda_host = 1'b1;
        addr_sel = 2'b01; parallel_in = 8'h5C;
        strobe_cnt = 0; last_idx = '0; oe_seen = 1'b0;
        for (int unsigned i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        tick(5);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_strobe", wr_strobe, 1'b0);
        check("rst_wr_index", wr_index, 4'd0);
        check("rst_packed", registers_packed, exp_packed());
        reset = 1'b0;
        tick(5);
        check("rst_reg_out", reg_out, 8'h5C);

        // Single write: reg3 <- A5
        start_cond();
        write_byte(8'h42, a); check("t1_addr_ack", a, 1'b0);
        write_byte(8'h03, a); check("t1_ptr_ack", a, 1'b0);
        write_byte(8'hA5, a); check("t1_data_ack", a, 1'b0);
        stop_cond();
        exp_regs[3] = 8'hA5;
        check("t1_packed", registers_packed, exp_packed());
        check("t1_strobe_cnt", strobe_cnt, 1);
        check("t1_wr_index", last_idx, 4'd3);

        wr_reg(8'h02, 8'h3C);
        wr_reg(8'h01, 8'h77);
        check("t1b_strobe_cnt", strobe_cnt, 3);

        // Burst across the wrap point
        strobe_cnt = 0;
        start_cond();
        write_byte(8'h42, a); check("t2_addr_ack", a, 1'b0);
        write_byte(8'h0F, a); check("t2_ptr_ack", a, 1'b0);
        write_byte(8'h11, a); check("t2_d0_ack", a, 1'b0);
        write_byte(8'h22, a); check("t2_d1_ack", a, 1'b0);
        stop_cond();
        exp_regs[15] = 8'h11;
        check("t2_packed", registers_packed, exp_packed());
        check("t2_strobe_cnt", strobe_cnt, 1);
        check("t2_wr_index", last_idx, 4'd15);
        check("t2_ptr_reg1", reg_out, 8'h77);

        // Pointer set, repeated START, two-byte read
        start_cond();
        write_byte(8'h42, a); check("t3_addr_ack", a, 1'b0);
        write_byte(8'h02, a); check("t3_ptr_ack", a, 1'b0);
        start_cond();
        write_byte(8'h43, a); check("t3_raddr_ack", a, 1'b0);
        read_byte(1'b0, d);   check("t3_rd0", d, 8'h3C);
        read_byte(1'b1, d);   check("t3_rd1", d, 8'hA5);
        stop_cond();
        check("t3_ptr_after", reg_out, 8'h00);

        // Read of status register 0
        start_cond();
        write_byte(8'h42, a);
        write_byte(8'h00, a); check("t3b_ptr0_ack", a, 1'b0);
        stop_cond();
        start_cond();
        write_byte(8'h43, a);
        read_byte(1'b1, d);   check("t3b_status", d, 8'h5C);
        stop_cond();
        check("t3b_ptr_after", reg_out, 8'h77);

        // Foreign address 0x30
        oe_seen = 1'b0; strobe_cnt = 0;
        start_cond();
        write_byte(8'h60, a); check("t4_addr_nack", a, 1'b1);
        write_byte(8'h05, a);
        write_byte(8'h99, a);
        stop_cond();
        check("t4_oe_never", oe_seen, 1'b0);
        check("t4_packed", registers_packed, exp_packed());
        check("t4_ptr", reg_out, 8'h77);

        // Out-of-range pointer 0x20
        start_cond();
        write_byte(8'h42, a); check("t5_addr_ack", a, 1'b0);
        write_byte(8'h20, a); check("t5_ptr_nack", a, 1'b1);
        write_byte(8'h55, a); check("t5_data_ignored", a, 1'b1);
        stop_cond();
        check("t5_packed", registers_packed, exp_packed());
        check("t5_strobe_cnt", strobe_cnt, 0);
        check("t5_ptr", reg_out, 8'h77);

`ifdef I2C_TIMEOUT_EN
        // SCL stalled low while the target drives a 0 bit
        begin
            int  n;
            logic hi;
            start_cond();
            write_byte(8'h42, a);
            write_byte(8'h03, a);
            start_cond();
            write_byte(8'h43, a);
            sda_host = 1'b1; tick(Q);
            scl_host = 1'b1; tick(2*Q);
            scl_host = 1'b0;
            n = 0; hi = 1'b0;
            while (n < 400) begin
                tick(1);
                n++;
                if (sda_oe) hi = 1'b1;
                else if (hi) break;
            end
            check("to_drove", hi, 1'b1);
            check("to_release_window", (n >= 100 && n <= 106), 1'b1);
            check("to_packed", registers_packed, exp_packed());
            oe_seen = 1'b0;
            send_bit(1'b1);
            send_bit(1'b1);
            check("to_idle", oe_seen, 1'b0);
            stop_cond();
        end
`endif

        // Reset in the middle of a read byte
        start_cond();
        write_byte(8'h42, a);
        write_byte(8'h03, a);
        start_cond();
        write_byte(8'h43, a); check("t6_raddr_ack", a, 1'b0);
        sda_host = 1'b1; tick(Q);
        scl_host = 1'b1; tick(2*Q);
        scl_host = 1'b0; tick(Q);
        check("t6_driving_bit6", sda_oe, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t6_rst_release", sda_oe, 1'b0);
        for (int unsigned i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        tick(2);
        check("t6_rst_packed", registers_packed, exp_packed());
        check("t6_rst_ptr", reg_out, 8'h5C);
        reset = 1'b0;
        tick(4);
        stop_cond();
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
